// File: rtl/nios_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEFAULT_EXPECTED_TS = 32'h51B0_D7C0;

endpackage

// File: rtl/sysid_timeout_counter.sv
// Per-transaction watchdog: counts cycles while enabled, saturates at LIMIT.
module sysid_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW     = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up to LIMIT and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                     cnt_d = '0;
    else if (enable && cnt_q != LIM) cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // High in the cycle whose closing edge brings the count to LIMIT.
  assign expired = enable && (cnt_q >= LIM_M1);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Reads sysid ID/timestamp words over Avalon-MM and reports pass/fail.
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_EXPECTED_TS,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout
);

  sysid_state_e state_q;
  logic         arm_q;
  logic         avm_read_q, avm_address_q;
  logic [31:0]  id_value_q, ts_value_q;
  logic         busy_q, done_q, pass_q, id_match_q, ts_match_q, timeout_q;

  logic tmo_clear, tmo_en, tmo_expired;
  logic id_hit, ts_hit_q, ts_hit_rd;

  // Counter restarts on every transition into a request state.
  assign tmo_en    = state_q inside {ST_ID_REQ, ST_ID_WAIT, ST_TS_REQ, ST_TS_WAIT};
  assign tmo_clear = ((state_q == ST_IDLE)    && (start || arm_q)) ||
                     ((state_q == ST_DONE)    && start)            ||
                     ((state_q == ST_ID_WAIT) && avm_readdatavalid);

  sysid_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  // Timestamp compare uses the incoming word so status lands with done.
  assign id_hit    = (id_value_q   == EXPECTED_ID);
  assign ts_hit_q  = (ts_value_q   == EXPECTED_TS);
  assign ts_hit_rd = (avm_readdata == EXPECTED_TS);

  // Control FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      arm_q         <= AUTO_START;
      avm_read_q    <= 1'b0;
      avm_address_q <= SYSID_ADDR_ID;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start || arm_q) begin
            arm_q         <= 1'b0;
            state_q       <= ST_ID_REQ;
            avm_read_q    <= 1'b1;
            avm_address_q <= SYSID_ADDR_ID;
            busy_q        <= 1'b1;
          end
        end
        ST_ID_REQ, ST_TS_REQ: begin
          // An accepted request takes priority over an expiring watchdog.
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            state_q    <= (state_q == ST_ID_REQ) ? ST_ID_WAIT : ST_TS_WAIT;
          end else if (tmo_expired) begin
            avm_read_q <= 1'b0;
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            pass_q     <= 1'b0;
            id_match_q <= id_hit;
            ts_match_q <= ts_hit_q;
          end
        end
        ST_ID_WAIT: begin
          if (avm_readdatavalid) begin
            id_value_q    <= avm_readdata;
            state_q       <= ST_TS_REQ;
            avm_read_q    <= 1'b1;
            avm_address_q <= SYSID_ADDR_TS;
          end else if (tmo_expired) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            pass_q     <= 1'b0;
            id_match_q <= id_hit;
            ts_match_q <= ts_hit_q;
          end
        end
        ST_TS_WAIT: begin
          state_q <= (avm_readdatavalid || tmo_expired) ? ST_DONE : ST_TS_WAIT;
          if (avm_readdatavalid) begin
            ts_value_q <= avm_readdata;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            id_match_q <= id_hit;
            ts_match_q <= ts_hit_rd;
            pass_q     <= id_hit && (ts_hit_rd || !CHECK_TS);
          end else if (tmo_expired) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            pass_q     <= 1'b0;
            id_match_q <= id_hit;
            ts_match_q <= ts_hit_q;
          end
        end
        ST_DONE: begin
          // Restart wipes the previous result before the new run begins.
          if (start) begin
            state_q       <= ST_ID_REQ;
            avm_read_q    <= 1'b1;
            avm_address_q <= SYSID_ADDR_ID;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            id_match_q    <= 1'b0;
            ts_match_q    <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          avm_read_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Self-checking bench: bench-driven sysid slave, result model from the rules.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h51B0_D7C0;
  localparam int          TMO    = 8;

  logic        clock = 1'b0;
  logic        reset, start, wr, rdv;
  logic [31:0] rdata;

  logic        a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to;
  logic [31:0] a_id, a_ts;
  logic        b_addr, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
  logic [31:0] b_id, b_ts;

  int errors = 0;
  int checks = 0;
  int cyc;

  always #5 clock = ~clock;

  // Cycles since the last edge that sampled reset high.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  nios_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
    .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
  ) u_a (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(wr),
    .avm_readdatavalid(rdv), .avm_readdata(rdata),
    .id_value(a_id), .ts_value(a_ts), .busy(a_busy), .done(a_done),
    .pass(a_pass), .id_match(a_idm), .ts_match(a_tsm), .timeout(a_to)
  );

  // Same stimulus, timestamp ignored for pass.
  nios_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
    .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
  ) u_b (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(wr),
    .avm_readdatavalid(rdv), .avm_readdata(rdata),
    .id_value(b_id), .ts_value(b_ts), .busy(b_busy), .done(b_done),
    .pass(b_pass), .id_match(b_idm), .ts_match(b_tsm), .timeout(b_to)
  );

  function automatic bit model_pass(logic [31:0] id, logic [31:0] ts, bit check_ts, bit to);
    return (id == EXP_ID) && (!check_ts || ts == EXP_TS) && !to;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Acts as the slave for one read: stall, accept, return data after lat cycles.
  task automatic serve(input logic exp_addr, input int stall, input int lat,
                       input logic [31:0] data, input bit start_in_wait);
    int n = 0;
    while (!a_read && n < 20) begin tick(); n++; end
    checks++;
    if (a_read !== 1'b1 || a_addr !== exp_addr) begin
      errors++;
      $display("FAIL read_issue: read=%b addr=%b, required read=1 addr=%b", a_read, a_addr, exp_addr);
    end
    for (int i = 0; i < stall; i++) begin
      wr = 1'b1;
      tick();
      checks++;
      if (a_read !== 1'b1 || a_addr !== exp_addr) begin
        errors++;
        $display("FAIL hold_stable: read=%b addr=%b, required read=1 addr=%b", a_read, a_addr, exp_addr);
      end
    end
    wr = 1'b0;
    tick();
    checks++;
    if (a_read !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL accept: read=%b busy=%b, required read=0 busy=1", a_read, a_busy);
    end
    for (int i = 0; i < lat - 1; i++) begin
      if (start_in_wait && i == 0) start = 1'b1;
      tick();
      start = 1'b0;
    end
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL early_done: done=%b, required 0", a_done);
    end
    rdv   = 1'b1;
    rdata = data;
    tick();
    rdv   = 1'b0;
    rdata = $urandom;
  endtask

  // Full check run starting from origin cycle o; verifies timing and status.
  task automatic run_check(input int o, input int s1, input int l1, input int s2, input int l2,
                           input logic [31:0] id, input logic [31:0] ts, input bit sw);
    int  exp_cyc;
    bit  ea, eb;
    exp_cyc = o + (s1 + 1 + l1) + (s2 + 1 + l2);
    ea = model_pass(id, ts, 1'b1, 1'b0);
    eb = model_pass(id, ts, 1'b0, 1'b0);
    serve(1'b0, s1, l1, id, 1'b0);
    serve(1'b1, s2, l2, ts, sw);
    checks++;
    if (a_done !== 1'b1 || cyc != exp_cyc) begin
      errors++;
      $display("FAIL done_time: done=%b cyc=%0d, required done=1 cyc=%0d", a_done, cyc, exp_cyc);
    end
    checks++;
    if (a_id !== id || a_ts !== ts) begin
      errors++;
      $display("FAIL latched: id=%h ts=%h, required id=%h ts=%h", a_id, a_ts, id, ts);
    end
    checks++;
    if (a_idm !== (id == EXP_ID) || a_tsm !== (ts == EXP_TS) || a_to !== 1'b0) begin
      errors++;
      $display("FAIL match: idm=%b tsm=%b to=%b, required idm=%b tsm=%b to=0",
               a_idm, a_tsm, a_to, id == EXP_ID, ts == EXP_TS);
    end
    checks++;
    if (a_pass !== ea || b_pass !== eb) begin
      errors++;
      $display("FAIL pass: a=%b b=%b, required a=%b b=%b", a_pass, b_pass, ea, eb);
    end
    checks++;
    if (a_busy !== 1'b0 || a_read !== 1'b0) begin
      errors++;
      $display("FAIL idle_after: busy=%b read=%b, required 0 0", a_busy, a_read);
    end
  endtask

  // Pulses start from DONE and checks the cleared status; returns origin cycle.
  task automatic do_start(output int o);
    start = 1'b1;
    tick();
    start = 1'b0;
    o = cyc;
    checks++;
    if ({a_done, a_pass, a_idm, a_tsm, a_to, a_id, a_ts} !== '0 || a_busy !== 1'b1 || a_read !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: done=%b pass=%b idm=%b tsm=%b to=%b id=%h ts=%h busy=%b read=%b, required all 0 busy=1 read=1",
               a_done, a_pass, a_idm, a_tsm, a_to, a_id, a_ts, a_busy, a_read);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; wr = 1'b0; rdv = 1'b0; rdata = '0;
    tick(); tick(); tick();
    checks++;
    if ({a_read, a_addr, a_id, a_ts, a_busy, a_done, a_pass, a_idm, a_tsm, a_to} !== '0) begin
      errors++;
      $display("FAIL reset_state: read=%b busy=%b done=%b pass=%b id=%h ts=%h, required all 0",
               a_read, a_busy, a_done, a_pass, a_id, a_ts);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero_wait();
    run_check(1, 0, 1, 0, 1, EXP_ID, EXP_TS, 1'b0);
  endtask

  task automatic test_waitrequest();
    int o;
    do_start(o);
    run_check(o, 3, 1, 3, 1, EXP_ID, EXP_TS, 1'b0);
  endtask

  task automatic test_mismatch();
    int o;
    do_start(o);
    run_check(o, 0, 1, 0, 1, 32'h0000_0001, EXP_TS, 1'b0);
    do_start(o);
    run_check(o, 1, 2, 0, 1, EXP_ID, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_random();
    int o;
    logic [31:0] id, ts;
    for (int k = 0; k < 10; k++) begin
      id = $urandom_range(0, 1) ? EXP_ID : $urandom;
      ts = $urandom_range(0, 1) ? EXP_TS : $urandom;
      do_start(o);
      run_check(o, $urandom_range(0, 3), $urandom_range(1, 3),
                   $urandom_range(0, 3), $urandom_range(1, 3), id, ts, 1'b0);
    end
  endtask

  // Data arriving on the very cycle the watchdog expires must still count.
  task automatic test_timeout_boundary();
    int o;
    do_start(o);
    run_check(o, 3, TMO - 4, 0, 1, EXP_ID, EXP_TS, 1'b0);
  endtask

  task automatic test_timeout();
    int o, n, st;
    bit saw_ts;
    // Read accepted, data never comes back.
    st = $urandom_range(0, 3);
    do_start(o);
    for (int i = 0; i < st; i++) begin wr = 1'b1; tick(); end
    wr = 1'b0;
    tick();
    n = 0; saw_ts = 1'b0;
    while (!a_done && n < 20) begin
      if (a_read && a_addr) saw_ts = 1'b1;
      tick(); n++;
    end
    checks++;
    if (a_done !== 1'b1 || a_to !== 1'b1 || cyc != o + TMO) begin
      errors++;
      $display("FAIL timeout_wait: done=%b to=%b cyc=%0d, required done=1 to=1 cyc=%0d", a_done, a_to, cyc, o + TMO);
    end
    checks++;
    if (a_pass !== 1'b0 || b_pass !== 1'b0 || a_read !== 1'b0 || a_busy !== 1'b0 || a_ts !== 32'h0 || saw_ts) begin
      errors++;
      $display("FAIL timeout_status: pass=%b/%b read=%b busy=%b ts=%h ts_read=%b, required 0/0 0 0 0 0",
               a_pass, b_pass, a_read, a_busy, a_ts, saw_ts);
    end
    // Request never accepted.
    do_start(o);
    wr = 1'b1;
    n = 0;
    while (!a_done && n < 20) begin tick(); n++; end
    wr = 1'b0;
    checks++;
    if (a_done !== 1'b1 || a_to !== 1'b1 || a_read !== 1'b0 || a_pass !== 1'b0 || cyc != o + TMO) begin
      errors++;
      $display("FAIL timeout_req: done=%b to=%b read=%b pass=%b cyc=%0d, required 1 1 0 0 cyc=%0d",
               a_done, a_to, a_read, a_pass, cyc, o + TMO);
    end
  endtask

  task automatic test_start_ignored();
    int o;
    do_start(o);
    run_check(o, 0, 1, 1, 3, EXP_ID, EXP_TS, 1'b1);
  endtask

  task automatic test_reset_midrun();
    int o;
    do_start(o);
    wr = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({a_read, a_busy, a_done, a_pass, a_id, a_ts, a_idm, a_tsm, a_to} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: read=%b busy=%b done=%b id=%h, required all 0", a_read, a_busy, a_done, a_id);
    end
    rdv = 1'b1; rdata = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0;
    tick();
    rdv = 1'b0;
    checks++;
    if (a_id !== 32'h0 || a_read !== 1'b1 || a_addr !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: id=%h read=%b addr=%b, required id=0 read=1 addr=0", a_id, a_read, a_addr);
    end
    run_check(1, 0, 1, 0, 1, EXP_ID, EXP_TS, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_waitrequest();
    test_mismatch();
    test_random();
    test_timeout_boundary();
    test_timeout();
    test_start_ignored();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
